// File: rtl/sdram_uart_dumper.sv
// Memory dump sequencer: walks an address window through sdram_controller's read port
// and streams each 16-bit word out of an 8N1 UART, high byte first.
module sdram_uart_dumper #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [21:0] START_ADDR   = 22'h000000,
   parameter logic [21:0] END_ADDR     = 22'h3FFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [21:0] addr_usr,
   output logic        do_command,
   input  logic        data_rdy,
   input  logic [15:0] data_out_usr,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [3:0] {
      IDLE, WAIT_RDY, REQ, REL, WAIT_BUSY, WAIT_DATA,
      CAPTURE, TX_HI, TX_LO, NEXT, FINISH
   } state_t;

   state_t           state;
   logic [15:0]      word;
   logic [CNT_W-1:0] baud_cnt;
   logic [3:0]       bit_idx;
   logic [7:0]       cur_byte;
   logic             next_bit;

   // Level of the bit that follows bit_idx within the current frame.
   always_comb begin
      cur_byte = (state == TX_LO) ? word[7:0] : word[15:8];
      next_bit = 1'b1;
      if (bit_idx < 4'd8)
         next_bit = cur_byte[bit_idx[2:0]];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         addr_usr   <= START_ADDR;
         do_command <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         word       <= '0;
         baud_cnt   <= '0;
         bit_idx    <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (start) begin
               addr_usr <= START_ADDR;
               busy     <= 1'b1;
               state    <= WAIT_RDY;
            end
            WAIT_RDY: if (data_rdy) begin
               do_command <= 1'b1;
               state      <= REQ;
            end
            REQ: begin
               do_command <= 1'b0;
               state      <= REL;
            end
            REL:       state <= WAIT_BUSY;
            WAIT_BUSY: if (!data_rdy) state <= WAIT_DATA;
            WAIT_DATA: if (data_rdy) state <= CAPTURE;
            CAPTURE: begin
               word     <= data_out_usr;
               tx       <= 1'b0;
               baud_cnt <= '0;
               bit_idx  <= '0;
               state    <= TX_HI;
            end
            TX_HI, TX_LO: begin
               if (baud_cnt != BAUD_LAST) begin
                  baud_cnt <= baud_cnt + 1'b1;
               end else begin
                  baud_cnt <= '0;
                  if (bit_idx == 4'd9) begin
                     bit_idx <= '0;
                     if (state == TX_HI) begin
                        tx    <= 1'b0;
                        state <= TX_LO;
                     end else begin
                        // done is raised on NEXT entry so it lands right after the stop bit
                        tx    <= 1'b1;
                        done  <= (addr_usr == END_ADDR);
                        state <= NEXT;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= next_bit;
                  end
               end
            end
            NEXT: if (addr_usr == END_ADDR) begin
               busy  <= 1'b0;
               state <= FINISH;
            end else begin
               addr_usr <= addr_usr + 1'b1;
               state    <= WAIT_RDY;
            end
            FINISH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_uart_dumper.sv
// Directed bench: two dumper instances (window 0..2 and single word 3FFFFF), each with a
// behavioural controller model, a do_command logger and a UART frame decoder.
module tb_sdram_uart_dumper;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic log_clr = 1'b0;
   int   init_len = 3;
   int   stale_hold = 0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(negedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : u
      localparam logic [21:0] SA = (g == 0) ? 22'h000000 : 22'h3FFFFF;
      localparam logic [21:0] EA = (g == 0) ? 22'h000002 : 22'h3FFFFF;

      logic        start_i, do_command, data_rdy, tx, busy, done;
      logic [21:0] addr_usr;
      logic [15:0] data_out_usr;

      assign start_i = (g == 0) ? start0 : start1;

      sdram_uart_dumper #(.CLKS_PER_BIT(4), .START_ADDR(SA), .END_ADDR(EA)) dut (
         .clk(clk), .reset(reset), .start(start_i), .addr_usr(addr_usr),
         .do_command(do_command), .data_rdy(data_rdy), .data_out_usr(data_out_usr),
         .tx(tx), .busy(busy), .done(done)
      );

      // Controller model: 0=init, 1=idle, 2=stale hold, 3=read latency
      int          m_st, m_cnt;
      logic        prev_cmd;
      logic [21:0] m_addr;
      always @(posedge clk or posedge reset) begin
         if (reset) begin
            data_rdy     <= 1'b0;
            data_out_usr <= 16'h0000;
            m_st         <= 0;
            m_cnt        <= init_len;
            prev_cmd     <= 1'b0;
            m_addr       <= '0;
         end else begin
            prev_cmd <= do_command;
            case (m_st)
               0: if (m_cnt <= 1) begin data_rdy <= 1'b1; m_st <= 1; end
                  else m_cnt <= m_cnt - 1;
               1: begin
                  if (do_command && !prev_cmd) m_addr <= addr_usr;
                  if (!do_command && prev_cmd) begin
                     if (stale_hold == 0) begin data_rdy <= 1'b0; m_st <= 3; m_cnt <= 5; end
                     else begin m_st <= 2; m_cnt <= stale_hold; end
                  end
               end
               2: if (m_cnt <= 1) begin data_rdy <= 1'b0; m_st <= 3; m_cnt <= 5; end
                  else m_cnt <= m_cnt - 1;
               3: if (m_cnt <= 1) begin
                     data_rdy     <= 1'b1;
                     data_out_usr <= m_addr[15:0] ^ 16'hA5A5;
                     m_st         <= 1;
                  end else m_cnt <= m_cnt - 1;
               default: m_st <= 0;
            endcase
         end
      end

      // Logger and UART decoder, sampled on the falling edge
      int          n_cmd = 0, cmd_w = 0, bad_w = 0, n_rx = 0, bad_stop = 0;
      int          done_cnt = 0, done_cyc = 0, last_start = 0, busy_gap = 0, fr_cnt = 0;
      logic        armed = 1'b0, in_fr = 1'b0;
      logic [7:0]  sh = '0;
      logic [21:0] cmd_addr [8];
      logic [7:0]  rx [16];
      always @(negedge clk) begin
         if (reset || log_clr) begin
            n_cmd <= 0; cmd_w <= 0; bad_w <= 0; n_rx <= 0; bad_stop <= 0;
            done_cnt <= 0; done_cyc <= 0; last_start <= 0; busy_gap <= 0;
            armed <= 1'b0; in_fr <= 1'b0; fr_cnt <= 0;
         end else begin
            if (do_command) begin
               if (cmd_w == 0) begin
                  if (n_cmd < 8) cmd_addr[n_cmd] <= addr_usr;
                  n_cmd <= n_cmd + 1;
               end
               cmd_w <= cmd_w + 1;
            end else begin
               if (cmd_w > 1) bad_w <= bad_w + 1;
               cmd_w <= 0;
            end
            if (done) begin
               done_cnt <= done_cnt + 1;
               done_cyc <= cyc;
               armed    <= 1'b0;
            end else if (busy && !armed) armed <= 1'b1;
            else if (armed && !busy) busy_gap <= busy_gap + 1;
            if (!in_fr) begin
               if (!tx) begin in_fr <= 1'b1; fr_cnt <= 1; last_start <= cyc; end
            end else begin
               fr_cnt <= fr_cnt + 1;
               if (fr_cnt >= 6 && fr_cnt <= 34 && (fr_cnt % 4) == 2)
                  sh[(fr_cnt - 6) / 4] <= tx;
               if (fr_cnt == 38) begin
                  if (n_rx < 16) rx[n_rx] <= sh;
                  n_rx <= n_rx + 1;
                  if (!tx) bad_stop <= bad_stop + 1;
                  in_fr <= 1'b0;
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start0();
      start0 = 1'b1; tick(1); start0 = 1'b0;
   endtask

   task automatic clear_log();
      log_clr = 1'b1; @(negedge clk); #1; log_clr = 1'b0;
   endtask

   task automatic wait_done0(input string tag);
      int k = 0;
      while (u[0].done_cnt == 0 && k < 2000) begin tick(1); k++; end
      chk({tag, "_done_seen"}, 32'(u[0].done_cnt != 0), 32'd1);
      tick(3);
   endtask

   function automatic logic [15:0] exp_word(input logic [21:0] a);
      return a[15:0] ^ 16'hA5A5;
   endfunction

   // Full run of instance 0: three single-cycle requests at 0,1,2 and six matching bytes
   task automatic check_run0(input string tag);
      logic [15:0] w;
      chk({tag, "_ncmd"}, 32'(u[0].n_cmd), 32'd3);
      chk({tag, "_cmd_width"}, 32'(u[0].bad_w), 32'd0);
      chk({tag, "_nbytes"}, 32'(u[0].n_rx), 32'd6);
      chk({tag, "_framing"}, 32'(u[0].bad_stop), 32'd0);
      chk({tag, "_ndone"}, 32'(u[0].done_cnt), 32'd1);
      for (int i = 0; i < 3; i++) begin
         w = exp_word(22'(i));
         chk({tag, "_addr"}, 32'(u[0].cmd_addr[i]), 32'(i));
         chk({tag, "_byte_hi"}, 32'(u[0].rx[2*i]), 32'(w[15:8]));
         chk({tag, "_byte_lo"}, 32'(u[0].rx[2*i+1]), 32'(w[7:0]));
      end
   endtask

   initial begin
      // Reset values
      tick(2);
      chk("rst_tx", 32'(u[0].tx), 32'd1);
      chk("rst_cmd", 32'(u[0].do_command), 32'd0);
      chk("rst_busy", 32'(u[0].busy), 32'd0);
      chk("rst_done", 32'(u[0].done), 32'd0);
      chk("rst_addr0", 32'(u[0].addr_usr), 32'h000000);
      chk("rst_addr1", 32'(u[1].addr_usr), 32'h3FFFFF);

      // Basic dump after controller init
      reset = 1'b0;
      tick(10);
      clear_log();
      pulse_start0();
      chk("t1_busy_start", 32'(u[0].busy), 32'd1);
      wait_done0("t1");
      check_run0("t1");
      chk("t1_done_delay", 32'(u[0].done_cyc - u[0].last_start), 32'd40);
      chk("t1_busy_gap", 32'(u[0].busy_gap), 32'd0);
      chk("t1_busy_end", 32'(u[0].busy), 32'd0);
      chk("t1_addr_hold", 32'(u[0].addr_usr), 32'd2);

      // Start while the controller is still initialising
      init_len = 8;
      reset = 1'b1; tick(2); reset = 1'b0;
      tick(1);
      pulse_start0();
      tick(3);
      chk("t2_rdy_low", 32'(u[0].data_rdy), 32'd0);
      chk("t2_no_cmd", 32'(u[0].n_cmd), 32'd0);
      chk("t2_busy", 32'(u[0].busy), 32'd1);
      wait_done0("t2");
      check_run0("t2");
      init_len = 3;

      // data_rdy stays high two cycles past the request: no early capture
      stale_hold = 2;
      clear_log();
      pulse_start0();
      wait_done0("t3");
      check_run0("t3");
      stale_hold = 0;

      // Repeated starts while busy are ignored
      clear_log();
      pulse_start0();
      for (int i = 0; i < 5; i++) begin tick(40); pulse_start0(); end
      wait_done0("t4");
      tick(20);
      check_run0("t4");

      // Reset in the middle of the low byte
      clear_log();
      pulse_start0();
      begin
         int k = 0;
         while (!(u[0].n_rx == 1 && u[0].tx == 1'b0) && k < 2000) begin tick(1); k++; end
      end
      chk("t5_pre_tx_low", 32'(u[0].tx), 32'd0);
      reset = 1'b1; #1;
      chk("t5_rst_tx", 32'(u[0].tx), 32'd1);
      chk("t5_rst_cmd", 32'(u[0].do_command), 32'd0);
      chk("t5_rst_busy", 32'(u[0].busy), 32'd0);
      chk("t5_rst_done", 32'(u[0].done), 32'd0);
      chk("t5_rst_addr", 32'(u[0].addr_usr), 32'd0);
      tick(2);
      reset = 1'b0;
      tick(1);
      pulse_start0();
      wait_done0("t5");
      check_run0("t5");

      // Single-word window at the top of the address space
      start1 = 1'b1; tick(1); start1 = 1'b0;
      begin
         int k = 0;
         while (u[1].done_cnt == 0 && k < 2000) begin tick(1); k++; end
      end
      tick(3);
      chk("t6_done_seen", 32'(u[1].done_cnt), 32'd1);
      chk("t6_ncmd", 32'(u[1].n_cmd), 32'd1);
      chk("t6_addr", 32'(u[1].cmd_addr[0]), 32'h3FFFFF);
      chk("t6_nbytes", 32'(u[1].n_rx), 32'd2);
      chk("t6_byte_hi", 32'(u[1].rx[0]), 32'h5A);
      chk("t6_byte_lo", 32'(u[1].rx[1]), 32'h5A);
      chk("t6_addr_hold", 32'(u[1].addr_usr), 32'h3FFFFF);
      chk("t6_busy_end", 32'(u[1].busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
